// File: rtl/nios2_system_evt_pio_if.sv
`default_nettype none
// ============================================================================
// Module   : nios2_system_evt_pio_if
// Brief    : Avalon-MM slave bus bundle for the event PIO register block.
// Revision : 1.0
// ============================================================================
interface nios2_system_evt_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface
`default_nettype wire

// File: rtl/nios2_system_evt_pio.sv
`default_nettype none
// ============================================================================
// Module   : nios2_system_evt_pio
// Brief    : Edge-capturing PIO with maskable level interrupt, Avalon-MM slave.
//            Optional 16-bit event counter at address 2: NIOS2_EVT_PIO_EVENT_COUNT_EN.
// Revision : 1.0
// ============================================================================
module nios2_system_evt_pio #(
    parameter int WIDTH       = 8,
    parameter int EDGE_TYPE   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    nios2_system_evt_pio_if.slave bus,
    input  wire logic [WIDTH-1:0] in_port,
    output logic                  irq
);
    localparam logic [2:0] PRIME_DONE = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [2:0]       prime_q, prime_d;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [31:0]      readdata_q, readdata_d;

    logic [WIDTH-1:0] data_w;
    logic [WIDTH-1:0] raw_edge_w;
    logic [WIDTH-1:0] edge_w;
    logic [WIDTH-1:0] wdata_w;
    logic             wr_w;
    logic             any_edge_w;
    logic             unused_wdata;

    assign data_w       = sync_q[SYNC_STAGES-1];
    assign wdata_w      = bus.writedata[WIDTH-1:0];
    assign wr_w         = bus.chipselect & ~bus.write_n;
    assign unused_wdata = ^bus.writedata;

    generate
        if (EDGE_TYPE == 0) begin : g_rise
            assign raw_edge_w = data_w & ~prev_q;
        end else if (EDGE_TYPE == 1) begin : g_fall
            assign raw_edge_w = ~data_w & prev_q;
        end else begin : g_any
            assign raw_edge_w = data_w ^ prev_q;
        end
    endgenerate

    // Edges are masked until the synchronizer and prev hold real input samples.
    assign edge_w     = (prime_q == PRIME_DONE) ? raw_edge_w : '0;
    assign any_edge_w = |edge_w;

`ifdef NIOS2_EVT_PIO_EVENT_COUNT_EN
    logic [15:0] evcnt_q, evcnt_d;

    always_comb begin
        evcnt_d = evcnt_q;
        if (wr_w && bus.address == 2'd2) begin
            evcnt_d = any_edge_w ? 16'd1 : 16'd0;
        end else if (any_edge_w && evcnt_q != 16'hFFFF) begin
            evcnt_d = evcnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            evcnt_q <= '0;
        end else begin
            evcnt_q <= evcnt_d;
        end
    end
`else
    logic unused_any_edge;
    assign unused_any_edge = any_edge_w;
`endif

    always_comb begin
        sync_d = sync_q;
        sync_d[0] = in_port;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d  = data_w;
        prime_d = (prime_q == PRIME_DONE) ? prime_q : prime_q + 3'd1;

        irqmask_d = irqmask_q;
        if (wr_w && bus.address == 2'd1) begin
            irqmask_d = wdata_w;
        end

        // A fresh edge overrides a same-cycle clear of that bit.
        edgecap_d = edgecap_q;
        if (wr_w && bus.address == 2'd3) begin
            edgecap_d = edgecap_q & ~wdata_w;
        end
        edgecap_d = edgecap_d | edge_w;

        readdata_d = '0;
        case (bus.address)
            2'd0: readdata_d[WIDTH-1:0] = data_w;
            2'd1: readdata_d[WIDTH-1:0] = irqmask_q;
`ifdef NIOS2_EVT_PIO_EVENT_COUNT_EN
            2'd2: readdata_d[15:0] = evcnt_q;
`else
            2'd2: readdata_d = '0;
`endif
            default: readdata_d[WIDTH-1:0] = edgecap_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q     <= '0;
            prev_q     <= '0;
            prime_q    <= '0;
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
        end else begin
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            prime_q    <= prime_d;
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign irq          = |(edgecap_q & irqmask_q);

endmodule
`default_nettype wire

// File: tb/tb_nios2_system_evt_pio.sv
`default_nettype none
// ============================================================================
// Module   : tb_nios2_system_evt_pio
// Brief    : Directed self-checking bench: rising-edge instance and any-edge instance.
// Revision : 1.0
// ============================================================================
module tb_nios2_system_evt_pio;
    logic       clk;
    logic       reset_n;
    logic [7:0] in0;
    logic [7:0] in2;
    logic       irq0;
    logic       irq2;
    int         checks;
    int         errors;

    nios2_system_evt_pio_if bus0 ();
    nios2_system_evt_pio_if bus2 ();

    nios2_system_evt_pio #(.WIDTH(8), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0),
        .in_port (in0),
        .irq     (irq0)
    );

    nios2_system_evt_pio #(.WIDTH(8), .EDGE_TYPE(2), .SYNC_STAGES(2)) dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus2),
        .in_port (in2),
        .irq     (irq2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input int which, input logic [1:0] addr, input logic [31:0] data);
        if (which == 0) begin
            bus0.address = addr; bus0.writedata = data; bus0.chipselect = 1'b1; bus0.write_n = 1'b0;
        end else begin
            bus2.address = addr; bus2.writedata = data; bus2.chipselect = 1'b1; bus2.write_n = 1'b0;
        end
        tick(1);
        bus0.chipselect = 1'b0; bus0.write_n = 1'b1;
        bus2.chipselect = 1'b0; bus2.write_n = 1'b1;
    endtask

    task automatic bus_read(input int which, input logic [1:0] addr, output logic [31:0] data);
        if (which == 0) bus0.address = addr;
        else            bus2.address = addr;
        tick(1);
        data = (which == 0) ? bus0.readdata : bus2.readdata;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        reset_n = 1'b0;
        tick(3);
        checks++;
        if (bus0.readdata !== 32'h0 || irq0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: readdata=%h irq=%b, required 00000000/0", bus0.readdata, irq0);
        end
        reset_n = 1'b1;
        tick(6);
        bus_read(0, 2'd3, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL reset_edgecap: got %h, required 00000000", rd); end
        bus_read(0, 2'd1, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL reset_irqmask: got %h, required 00000000", rd); end
    endtask

    task automatic test_rising();
        logic [31:0] rd;
        bus0.address = 2'd0;
        in0 = 8'h05;
        tick(4);
        checks++;
        if (bus0.readdata !== 32'h05) begin errors++; $display("FAIL rise_data: got %h, required 00000005", bus0.readdata); end
        bus_read(0, 2'd3, rd);
        checks++;
        if (rd !== 32'h05) begin errors++; $display("FAIL rise_edgecap: got %h, required 00000005", rd); end
        checks++;
        if (irq0 !== 1'b0) begin errors++; $display("FAIL rise_irq_masked: got %b, required 0", irq0); end
    endtask

    task automatic test_irq();
        logic [31:0] rd;
        bus_write(0, 2'd1, 32'h04);
        checks++;
        if (irq0 !== 1'b1) begin errors++; $display("FAIL irq_assert: got %b, required 1", irq0); end
        bus_write(0, 2'd3, 32'h04);
        checks++;
        if (irq0 !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b, required 0", irq0); end
        bus_read(0, 2'd3, rd);
        checks++;
        if (rd !== 32'h01) begin errors++; $display("FAIL w1c_edgecap: got %h, required 00000001", rd); end
    endtask

    task automatic test_edge_wins();
        logic [31:0] rd;
        in0 = 8'h04;
        tick(5);
        bus_write(0, 2'd3, 32'h01);
        bus_read(0, 2'd3, rd);
        checks++;
        if (rd !== 32'h00) begin errors++; $display("FAIL fall_ignored: got %h, required 00000000", rd); end
        in0 = 8'h05;
        tick(2);
        bus_write(0, 2'd3, 32'h01);
        bus_read(0, 2'd3, rd);
        checks++;
        if (rd !== 32'h01) begin errors++; $display("FAIL edge_wins: got %h, required 00000001", rd); end
    endtask

    task automatic test_width_and_noop();
        logic [31:0] rd;
        bus_write(0, 2'd1, 32'hFFFF_FF0A);
        bus_read(0, 2'd1, rd);
        checks++;
        if (rd !== 32'h0A) begin errors++; $display("FAIL mask_upper_bits: got %h, required 0000000a", rd); end
        bus_write(0, 2'd0, 32'hFF);
        bus_read(0, 2'd0, rd);
        checks++;
        if (rd !== 32'h05) begin errors++; $display("FAIL addr0_noop: got %h, required 00000005", rd); end
        bus0.chipselect = 1'b0; bus0.write_n = 1'b0; bus0.address = 2'd1; bus0.writedata = 32'h0;
        tick(1);
        bus0.write_n = 1'b1;
        bus_read(0, 2'd1, rd);
        checks++;
        if (rd !== 32'h0A) begin errors++; $display("FAIL cs_low_ignored: got %h, required 0000000a", rd); end
    endtask

    task automatic test_high_at_reset();
        logic [31:0] rd;
        reset_n = 1'b0;
        in0 = 8'hFF;
        tick(2);
        reset_n = 1'b1;
        tick(8);
        bus_write(0, 2'd1, 32'hFF);
        bus_read(0, 2'd3, rd);
        checks++;
        if (rd !== 32'h00) begin errors++; $display("FAIL high_at_reset_edgecap: got %h, required 00000000", rd); end
        checks++;
        if (irq0 !== 1'b0) begin errors++; $display("FAIL high_at_reset_irq: got %b, required 0", irq0); end
    endtask

    task automatic test_any_edge();
        logic [31:0] rd;
        logic [31:0] exp_cnt;
`ifdef NIOS2_EVT_PIO_EVENT_COUNT_EN
        exp_cnt = 32'd4;
`else
        exp_cnt = 32'd0;
`endif
        for (int i = 0; i < 4; i++) begin
            in2 = in2 ^ 8'h08;
            tick(4);
        end
        bus_read(2, 2'd3, rd);
        checks++;
        if (rd !== 32'h08) begin errors++; $display("FAIL any_edgecap: got %h, required 00000008", rd); end
        bus_read(2, 2'd2, rd);
        checks++;
        if (rd !== exp_cnt) begin errors++; $display("FAIL event_count: got %h, required %h", rd, exp_cnt); end
        bus_write(2, 2'd2, 32'h0);
        bus_read(2, 2'd2, rd);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL event_count_clear: got %h, required 00000000", rd); end
        checks++;
        if (irq2 !== 1'b0) begin errors++; $display("FAIL any_irq_masked: got %b, required 0", irq2); end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        in0     = 8'h00;
        in2     = 8'h00;
        bus0.address = 2'd0; bus0.chipselect = 1'b0; bus0.write_n = 1'b1; bus0.writedata = 32'h0;
        bus2.address = 2'd0; bus2.chipselect = 1'b0; bus2.write_n = 1'b1; bus2.writedata = 32'h0;
        test_reset();
        test_rising();
        test_irq();
        test_edge_wins();
        test_width_and_noop();
        test_any_edge();
        test_high_at_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/nios2_system_evt_pio.md
NIOS2_SYSTEM_EVT_PIO -- requirements
Module: nios2_system_evt_pio

Interface
REQ-001 SHALL provide parameter WIDTH, default 8: number of input bits, legal range 1..32.
REQ-002 SHALL provide parameter EDGE_TYPE, default 0: 0 = rising, 1 = falling, 2 = any edge.
REQ-003 SHALL provide parameter SYNC_STAGES, default 2: input synchronizer depth, legal range 2..3.
REQ-004 SHALL provide port clk, input, 1 bit: system clock; all state is on its rising edge.
REQ-005 SHALL provide port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL provide port address, input, 2 bits: Avalon-MM word address.
REQ-007 SHALL provide port chipselect, input, 1 bit: slave select; writes are ignored when it is low.
REQ-008 SHALL provide port write_n, input, 1 bit: active-low write strobe.
REQ-009 SHALL provide port writedata, input, 32 bits: write data.
REQ-010 SHALL provide port in_port, input, WIDTH bits: asynchronous external inputs.
REQ-011 SHALL provide port readdata, output, 32 bits: registered read data.
REQ-012 SHALL provide port irq, output, 1 bit: level interrupt to the processor.

Function
REQ-013 SHALL pass each in_port bit through a SYNC_STAGES-flop synchronizer; the synchronized value is "data".
REQ-014 SHALL keep prev = data delayed by 1 cycle, and detect edges per bit:
- EDGE_TYPE 0: data & ~prev
- EDGE_TYPE 1: ~data & prev
- EDGE_TYPE 2: data ^ prev
REQ-015 SHALL, after reset, suppress edge detection for SYNC_STAGES+1 cycles using a priming counter, so inputs already high at reset release raise no event.
REQ-016 SHALL use the register map below:
- address 0: data, read-only.
- address 1: irqmask, read/write, WIDTH bits.
- address 2: event count, read; see REQ-025.
- address 3: edgecapture, read; a write clears bits per writedata bit (write-1-to-clear).
REQ-017 SHALL perform a write when chipselect=1 and write_n=0; it takes effect on the next clock edge.
REQ-018 SHALL set an edgecapture bit on a detected edge; the bit stays set until cleared.
REQ-019 SHALL, when an edge and a write-1-to-clear hit the same bit in the same cycle, leave the bit set (edge wins).
REQ-020 SHALL register readdata every cycle, with the address mux output zero-extended to 32 bits: 1-cycle read latency, and no dependence on chipselect.
REQ-021 SHALL drive irq = OR(edgecapture & irqmask), combinational from registers; irq asserts the cycle after edgecapture is set.
REQ-022 SHALL ignore writedata bits at or above WIDTH and read them back as 0.
REQ-023 SHALL treat writes to address 0 as no-ops.

Reset
REQ-024 SHALL, on reset_n low, asynchronously clear the following to 0: synchronizer flops, prev, priming counter, irqmask, edgecapture, event counter, readdata. irq SHALL therefore be 0 during reset, and reset mid-operation discards all pending captures.

Configuration
REQ-025 SHALL include a 16-bit event counter only when macro NIOS2_EVT_PIO_EVENT_COUNT_EN is defined:
- The counter increments by 1 in each cycle in which any bit detects an edge, and saturates at 0xFFFF.
- It reads at address 2.
- Any write to address 2 clears it; a write in the same cycle as an edge loads 1.
- Without the macro, the counter logic is not built, address 2 reads 0, and writes to it are ignored.

Verification
REQ-026 SHALL cover, WIDTH=8, EDGE_TYPE=0, in_port 0x00->0x05:
- data reads 0x05 by cycle SYNC_STAGES+2.
- edgecapture = 0x05.
- irq stays 0 while irqmask = 0.
REQ-027 SHALL cover irqmask=0x04 with edgecapture=0x05:
- irq=1.
- A write of 0x04 to address 3 gives edgecapture 0x01 and irq=0 the next cycle.
REQ-028 SHALL cover a write of 0x01 to address 3 in the same cycle a new rising edge is detected on bit 0: edgecapture bit 0 stays 1.
REQ-029 SHALL cover in_port held at 0xFF through reset release: edgecapture stays 0x00 and irq stays 0.
REQ-030 SHALL cover EDGE_TYPE=2, in_port toggling bit 3 four times, with the macro defined:
- edgecapture = 0x08.
- Address 2 reads 4.
- A write to address 2 makes it read 0.
REQ-031 SHALL cover the build without the macro: address 2 reads 0x00000000 after any edges.
